sint_minmax_sequencer: RTL and testbench
========================================

Name: sint_minmax_sequencer

Overview:
- Sequences one shared signed less-or-equal comparator (sle, WIDTH bits) across a burst of signed samples.
- Reports the burst's signed minimum, signed maximum and the index of each.
- Sits between a valid/ready sample producer and a valid/ready result consumer in magma-generated datapaths.
- The comparator is time-multiplexed: the min test and the max test run in separate cycles.

Parameters:
- WIDTH, 3, sample width; samples are two's-complement signed.
- IDX_W, 4, width of index/count fields; bursts longer than 2^IDX_W set overflow.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_data  in  WIDTH  signed sample.
- I_last  in  1  marks final sample of burst; qualified by the I handshake.
- I_valid  in  1  producer has a sample.
- I_ready  out  1  sequencer accepts the sample this cycle.
- O_min  out  WIDTH  signed minimum of burst.
- O_max  out  WIDTH  signed maximum of burst.
- O_min_idx  out  IDX_W  index of first occurrence of the minimum.
- O_max_idx  out  IDX_W  index of first occurrence of the maximum.
- O_count  out  IDX_W  number of samples minus 1, modulo 2^IDX_W.
- O_overflow  out  1  burst exceeded 2^IDX_W samples.
- O_valid  out  1  result available.
- O_ready  in  1  consumer takes the result.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, ports named CLK and RESET.
  - On RESET: state=FIRST, all output registers 0, I_ready=0 during the reset cycle, O_valid=0.
  - RESET mid-burst discards all partial results; no result is emitted.
- State FIRST (waiting for burst start):
  - I_ready=1.
  - On handshake: min=max=I_data, min_idx=max_idx=0, count=0, overflow=0.
  - Next state is DONE if I_last, else ACCEPT.
- State ACCEPT:
  - I_ready=1.
  - On handshake: sample_reg=I_data, count increments.
  - If count was 2^IDX_W-1, count wraps to 0 and overflow is set (sticky until next FIRST).
  - last_reg=I_last; next state CMP_MIN. No handshake means stay.
- State CMP_MIN:
  - I_ready=0. Comparator in0=min, in1=sample_reg.
  - If out==0 (sample strictly less than min): min=sample_reg, min_idx=count. Ties keep the earlier index.
  - Next state CMP_MAX.
- State CMP_MAX:
  - I_ready=0. Comparator in0=sample_reg, in1=max.
  - If out==0 (sample strictly greater than max): max=sample_reg, max_idx=count.
  - Next state DONE if last_reg, else ACCEPT.
- State DONE:
  - O_valid=1, I_ready=0. Outputs are registered and stable while O_valid && !O_ready.
  - On O_ready: next state FIRST, O_valid drops the following cycle.
  - A new burst is accepted no earlier than the cycle after the result handshake.
- Throughput and latency:
  - 1 sample per cycle for the first sample; 3 cycles per sample thereafter.
  - Result is valid 1 cycle after the last sample's compare (single-sample burst: O_valid the cycle after its handshake).
- Comparator rules:
  - Exactly one sle instance with width=WIDTH.
  - Operands are muxed by state; comparator output is ignored outside CMP_MIN/CMP_MAX.
  - All comparisons are signed; no widening.
- Boundary behaviour:
  - Most-negative value (-2^(WIDTH-1)) and most-positive value must order correctly.
  - I_valid low in ACCEPT inserts bubbles with no state change.
  - I_last in FIRST produces a one-sample result.

Decomposition:
- Shared package holds:
  - the state enum (FIRST, ACCEPT, CMP_MIN, CMP_MAX, DONE);
  - the signed sample typedef parameterised by WIDTH;
  - the index typedef.
- The sle comparator is a natural sub-module, instantiated once as coreir_sle.
- The sequencer holds the FSM, operand muxes and result registers.

Test Plan:
- WIDTH=3, burst [1,-3,2,-3,3,0] with last on 0 -> O_min=-3, O_min_idx=1, O_max=3, O_max_idx=4, O_count=5, O_overflow=0.
- Single sample -4 with I_last -> O_valid the next cycle; min=max=-4, both idx=0, count=0.
- Burst [-4,3] -> min=-4 idx0, max=3 idx1; checks signed extremes (unsigned compare would swap them).
- Burst of 17 samples with IDX_W=4 -> O_overflow=1, O_count=0; O_ready held low 5 cycles -> outputs stable, then a new burst is accepted only after the handshake.
- Assert RESET during CMP_MIN of a 4-sample burst -> O_valid never rises; a following burst [2,2] gives min=max=2, both idx=0.
- Random I_valid gaps in a burst [0,-1,1] -> I_ready=0 in the two compare cycles after each accept; result min=-1 idx1, max=1 idx2.

Source files
------------

// File: rtl/sint_minmax_sequencer_pkg.sv
// Shared types for the signed min/max burst sequencer.
package sint_minmax_sequencer_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_IDX_W = 4;

    typedef enum logic [2:0] {
        FIRST   = 3'd0,
        ACCEPT  = 3'd1,
        CMP_MIN = 3'd2,
        CMP_MAX = 3'd3,
        DONE    = 3'd4
    } state_e;

    typedef logic signed [DEF_WIDTH-1:0] sample_t;
    typedef logic [DEF_IDX_W-1:0] idx_t;

endpackage

// File: rtl/sint_minmax_sequencer_sle.sv
// Signed less-or-equal comparator, coreir primitive semantics.
module coreir_sle #(
    parameter int width = 3
) (
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    output logic             out
);

    assign out = $signed(in0) <= $signed(in1);

endmodule

// File: rtl/sint_minmax_sequencer.sv
// Burst signed min/max tracker sharing one sle comparator across
// separate min and max compare cycles.
import sint_minmax_sequencer_pkg::*;

module sint_minmax_sequencer #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_last,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O_min,
    output logic [WIDTH-1:0] O_max,
    output logic [IDX_W-1:0] O_min_idx,
    output logic [IDX_W-1:0] O_max_idx,
    output logic [IDX_W-1:0] O_count,
    output logic             O_overflow,
    output logic             O_valid,
    input  logic             O_ready
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             last_q, last_d;

    logic [WIDTH-1:0] cmp_in0;
    logic [WIDTH-1:0] cmp_in1;
    logic             cmp_out;
    logic             i_ready;
    logic             o_valid;

    coreir_sle #(
        .width(WIDTH)
    ) u_sle (
        .in0(cmp_in0),
        .in1(cmp_in1),
        .out(cmp_out)
    );

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        sample_d  = sample_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        last_d    = last_q;
        cmp_in0   = min_q;
        cmp_in1   = sample_q;
        i_ready   = 1'b0;
        o_valid   = 1'b0;

        unique case (state_q)
            FIRST: begin
                i_ready = 1'b1;
                if (I_valid) begin
                    min_d     = I_data;
                    max_d     = I_data;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    state_d   = I_last ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                i_ready = 1'b1;
                if (I_valid) begin
                    sample_d = I_data;
                    count_d  = count_q + 1'b1;
                    // Wrap past the index range marks the burst as too long.
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end
                    last_d  = I_last;
                    state_d = CMP_MIN;
                end
            end
            CMP_MIN: begin
                cmp_in0 = min_q;
                cmp_in1 = sample_q;
                if (!cmp_out) begin
                    min_d     = sample_q;
                    min_idx_d = count_q;
                end
                state_d = CMP_MAX;
            end
            CMP_MAX: begin
                cmp_in0 = sample_q;
                cmp_in1 = max_q;
                if (!cmp_out) begin
                    max_d     = sample_q;
                    max_idx_d = count_q;
                end
                state_d = last_q ? DONE : ACCEPT;
            end
            DONE: begin
                o_valid = 1'b1;
                if (O_ready) begin
                    state_d = FIRST;
                end
            end
            default: begin
                state_d = FIRST;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= FIRST;
            min_q     <= '0;
            max_q     <= '0;
            sample_q  <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            sample_q  <= sample_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
        end
    end

    assign I_ready    = i_ready && !RESET;
    assign O_valid    = o_valid && !RESET;
    assign O_min      = min_q;
    assign O_max      = max_q;
    assign O_min_idx  = min_idx_q;
    assign O_max_idx  = max_idx_q;
    assign O_count    = count_q;
    assign O_overflow = ovf_q;

endmodule

// File: tb/tb_sint_minmax_sequencer.sv
// Directed bench for sint_minmax_sequencer with WIDTH=3, IDX_W=4.
module tb_sint_minmax_sequencer;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic signed [2:0] I_data = '0;
    logic              I_last = 1'b0;
    logic              I_valid = 1'b0;
    logic              I_ready;
    logic signed [2:0] O_min;
    logic signed [2:0] O_max;
    logic [3:0]        O_min_idx;
    logic [3:0]        O_max_idx;
    logic [3:0]        O_count;
    logic              O_overflow;
    logic              O_valid;
    logic              O_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    sint_minmax_sequencer #(
        .WIDTH(3),
        .IDX_W(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .I_data(I_data),
        .I_last(I_last),
        .I_valid(I_valid),
        .I_ready(I_ready),
        .O_min(O_min),
        .O_max(O_max),
        .O_min_idx(O_min_idx),
        .O_max_idx(O_max_idx),
        .O_count(O_count),
        .O_overflow(O_overflow),
        .O_valid(O_valid),
        .O_ready(O_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int d, input logic l);
        int n;
        I_data  = 3'(d);
        I_last  = l;
        I_valid = 1'b1;
        n = 0;
        while (!I_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        tick();
        I_valid = 1'b0;
        I_last  = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!O_valid && n < 100) begin
            tick();
            n++;
        end
        chk("result_timeout", int'(O_valid), 1);
    endtask

    task automatic take_result();
        O_ready = 1'b1;
        tick();
        O_ready = 1'b0;
        chk("valid_drop", int'(O_valid), 0);
    endtask

    task automatic chk_res(input string tag, input int mn, input int mni,
                           input int mx, input int mxi, input int cnt,
                           input int ovf);
        chk({tag, "_min"}, int'(O_min), mn);
        chk({tag, "_min_idx"}, int'(O_min_idx), mni);
        chk({tag, "_max"}, int'(O_max), mx);
        chk({tag, "_max_idx"}, int'(O_max_idx), mxi);
        chk({tag, "_count"}, int'(O_count), cnt);
        chk({tag, "_ovf"}, int'(O_overflow), ovf);
    endtask

    initial begin
        #1;
        chk("rst_i_ready", int'(I_ready), 0);
        chk("rst_o_valid", int'(O_valid), 0);
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("post_rst_i_ready", int'(I_ready), 1);
        chk_res("post_rst", 0, 0, 0, 0, 0, 0);
        chk("post_rst_o_valid", int'(O_valid), 0);

        // Main burst; latency of one cycle after last compare.
        send(1, 1'b0);
        send(-3, 1'b0);
        send(2, 1'b0);
        send(-3, 1'b0);
        send(3, 1'b0);
        send(0, 1'b1);
        chk("b1_cmpmin_ready", int'(I_ready), 0);
        tick();
        chk("b1_cmpmax_ready", int'(I_ready), 0);
        chk("b1_not_yet_valid", int'(O_valid), 0);
        tick();
        chk("b1_valid", int'(O_valid), 1);
        chk_res("b1", -3, 1, 3, 4, 5, 0);
        take_result();

        // Single sample burst.
        send(-4, 1'b1);
        chk("single_valid", int'(O_valid), 1);
        chk_res("single", -4, 0, -4, 0, 0, 0);
        take_result();

        // Signed extremes.
        send(-4, 1'b0);
        send(3, 1'b1);
        wait_result();
        chk_res("ext", -4, 0, 3, 1, 1, 0);
        take_result();

        // 17-sample burst overflows the 4-bit count.
        for (int i = 0; i < 17; i++) begin
            if (i == 5) send(3, 1'b0);
            else if (i == 9) send(-4, 1'b0);
            else send(0, i == 16);
        end
        wait_result();
        I_data  = 3'(1);
        I_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ovf_hold_valid", int'(O_valid), 1);
            chk("ovf_hold_i_ready", int'(I_ready), 0);
            chk_res("ovf_hold", -4, 9, 3, 5, 0, 1);
            tick();
        end
        I_valid = 1'b0;
        take_result();
        chk("after_hs_i_ready", int'(I_ready), 1);

        // Reset during CMP_MIN of a 4-sample burst.
        send(1, 1'b0);
        send(2, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (O_valid) seen = 1;
                tick();
            end
            chk("rst_mid_no_valid", seen, 0);
        end
        send(2, 1'b0);
        send(2, 1'b1);
        wait_result();
        chk_res("rst_after", 2, 0, 2, 0, 1, 0);
        take_result();

        // Bubbles between accepts.
        tick();
        send(0, 1'b0);
        tick();
        tick();
        chk("gap_accept_ready", int'(I_ready), 1);
        send(-1, 1'b0);
        chk("gap_cmpmin_ready", int'(I_ready), 0);
        tick();
        chk("gap_cmpmax_ready", int'(I_ready), 0);
        tick();
        tick();
        tick();
        send(1, 1'b1);
        chk("gap_cmpmin_ready2", int'(I_ready), 0);
        tick();
        chk("gap_cmpmax_ready2", int'(I_ready), 0);
        wait_result();
        chk_res("gap", -1, 1, 1, 2, 2, 0);
        take_result();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
